// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock-like signal in clk_in cycles, with loss-of-signal timeout.
// Define CLK_METER_DUTY_EN to compile in the high-time counter, high_out and duty_ok.
module clk_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             duty_ok,
   output logic             timeout
);

   typedef enum logic {WAIT, MEAS} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   s_p0;
   logic                   s_d_p1;
   logic                   rise;
   logic [CNT_W-1:0]       pcnt;

   // Stage 0: synchronizer chain on the asynchronous input
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_p0 <= '0;
         s_d_p1  <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
         s_d_p1  <= s_p0;
      end
   end

   assign s_p0 = sync_p0[SYNC_STAGES-1];
   assign rise = s_p0 & ~s_d_p1;

   // Stage 1: period FSM; the rise cycle itself counts as cycle 1 of the new period
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state      <= WAIT;
         pcnt       <= '0;
         period_out <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            WAIT: begin
               if (rise) begin
                  pcnt    <= CNT_ONE;
                  timeout <= 1'b0;
                  state   <= MEAS;
               end
            end
            MEAS: begin
               if (rise) begin
                  period_out <= pcnt;
                  meas_valid <= 1'b1;
                  pcnt       <= CNT_ONE;
               end else if (pcnt == CNT_MAX) begin
                  timeout <= 1'b1;
                  state   <= WAIT;
               end else begin
                  pcnt <= pcnt + CNT_ONE;
               end
            end
            default: state <= WAIT;
         endcase
      end
   end

`ifdef CLK_METER_DUTY_EN
   logic [CNT_W-1:0] hcnt;

   // Balanced when |2*high - period| <= 1; one extra bit keeps 2*high from overflowing
   function automatic logic duty_balanced(input logic [CNT_W-1:0] high,
                                          input logic [CNT_W-1:0] period);
      logic signed [CNT_W+1:0] diff;
      logic signed [CNT_W+1:0] lim;
      lim  = $signed({{(CNT_W+1){1'b0}}, 1'b1});
      diff = $signed({1'b0, high, 1'b0}) - $signed({2'b00, period});
      return (diff <= lim) && (diff >= -lim);
   endfunction

   // Stage 1: high-time counter tracks the period FSM
   always_ff @(posedge clk_in) begin
      if (rst) begin
         hcnt     <= '0;
         high_out <= '0;
         duty_ok  <= 1'b0;
      end else if (rise && (state == MEAS)) begin
         high_out <= hcnt;
         duty_ok  <= duty_balanced(hcnt, pcnt);
         hcnt     <= CNT_ONE;
      end else if (rise) begin
         hcnt <= CNT_ONE;
      end else if ((state == MEAS) && (pcnt != CNT_MAX)) begin
         hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s_p0};
      end
   end
`else
   assign high_out = '0;
   assign duty_ok  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a CNT_W=16 instance for measurement/reset cases and a CNT_W=4 one for timeout.
module tb_clk_period_meter;

   localparam int SYNC = 2;
`ifdef CLK_METER_DUTY_EN
   localparam int DUTY = 1;
`else
   localparam int DUTY = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, sig16, rst4, sig4;
   logic [15:0] per16, hi16;
   logic [3:0]  per4, hi4;
   logic        mv16, dok16, to16, mv4, dok4, to4;

   clk_period_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
      .clk_in(clk), .rst(rst16), .sig_in(sig16), .period_out(per16), .high_out(hi16),
      .meas_valid(mv16), .duty_ok(dok16), .timeout(to16));

   clk_period_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
      .clk_in(clk), .rst(rst4), .sig_in(sig4), .period_out(per4), .high_out(hi4),
      .meas_valid(mv4), .duty_ok(dok4), .timeout(to4));

   typedef struct {int per; int hi; int dok; int cyc;} meas_t;

   int    cyc = 0;
   meas_t q16[$];
   meas_t q4[$];
   int    rises[$];
   int    tgt = 0;
   int    n_chk = 0;
   int    n_err = 0;
   int    tcyc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mv16) q16.push_back('{int'(per16), int'(hi16), int'(dok16), cyc});
      if (mv4)  q4.push_back('{int'(per4), int'(hi4), int'(dok4), cyc});
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sig(input bit v);
      if (tgt == 0) sig16 = v;
      else          sig4  = v;
   endtask

   task automatic wave(input int per, input int hi, input int n);
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < per; c++) begin
            if (c == 0) rises.push_back(cyc);
            set_sig(c < hi);
            tick();
         end
      end
   endtask

   task automatic idle(input int n);
      set_sig(1'b0);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      set_sig(1'b0);
      if (tgt == 0) rst16 = 1'b1;
      else          rst4  = 1'b1;
      tick();
      rst16 = 1'b0;
      rst4  = 1'b0;
      q16.delete();
      q4.delete();
      rises.delete();
   endtask

   task automatic check_q16(input string tag, input int n, input int per, input int hi, input int dok);
      check({tag, "_count"}, q16.size(), n);
      for (int i = 0; i < q16.size(); i++) begin
         check({tag, "_period"}, q16[i].per, per);
         check({tag, "_high"},   q16[i].hi,  hi);
         check({tag, "_duty"},   q16[i].dok, dok);
      end
   endtask

   initial begin
      rst16 = 1'b1; rst4 = 1'b1; sig16 = 1'b0; sig4 = 1'b0;
      tick(); tick();
      rst16 = 1'b0; rst4 = 1'b0;

      // Idle after reset: nothing measured, no timeout while waiting for a first edge
      idle(100);
      check("idle_meas16", q16.size(), 0);
      check("idle_meas4",  q4.size(), 0);
      check("idle_period", int'(per16), 0);
      check("idle_high",   int'(hi16), 0);
      check("idle_duty",   int'(dok16), 0);
      check("idle_to16",   int'(to16), 0);
      check("idle_to4",    int'(to4), 0);

      // Square wave 10/5
      tgt = 0;
      do_reset();
      wave(10, 5, 5);
      idle(5);
      check_q16("sq10", 4, 10, 5 * DUTY, DUTY);
      if (q16.size() > 0) check("sq10_latency", q16[0].cyc, rises[1] + SYNC + 1);
      check("sq10_valid_low", int'(mv16), 0);

      // Divide-by-5 divider model: high alternates 3 and 2 samples
      do_reset();
      for (int p = 0; p < 6; p++) wave(5, (p % 2 == 0) ? 3 : 2, 1);
      idle(5);
      check("div5_count", q16.size(), 5);
      for (int i = 0; i < q16.size(); i++) begin
         check("div5_period", q16[i].per, 5);
         check("div5_high",   q16[i].hi, ((i % 2 == 0) ? 3 : 2) * DUTY);
         check("div5_duty",   q16[i].dok, DUTY);
      end

      // Unbalanced 12/2
      do_reset();
      wave(12, 2, 3);
      idle(5);
      check_q16("p12h2", 2, 12, 2 * DUTY, 0);

      // Reset in the same cycle as a detected rise
      do_reset();
      wave(10, 5, 3);
      check("prerst_period", int'(per16), 10);
      sig16 = 1'b1;
      tick(); tick();
      rst16 = 1'b1;
      sig16 = 1'b0;
      tick();
      rst16 = 1'b0;
      check("rst_period", int'(per16), 0);
      check("rst_high",   int'(hi16), 0);
      check("rst_valid",  int'(mv16), 0);
      check("rst_duty",   int'(dok16), 0);
      check("rst_to",     int'(to16), 0);
      idle(4);
      check("rst_no_meas", q16.size(), 2);
      q16.delete();
      rises.delete();
      wave(10, 5, 3);
      idle(5);
      check_q16("postrst", 2, 10, 5 * DUTY, DUTY);
      if (q16.size() > 0) check("postrst_latency", q16[0].cyc, rises[1] + SYNC + 1);

      // Timeout on the CNT_W=4 instance
      tgt = 1;
      do_reset();
      wave(6, 3, 2);
      tcyc = -1;
      set_sig(1'b0);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (to4 && tcyc < 0) tcyc = cyc;
      end
      check("to_cycle",      tcyc, rises[1] + SYNC + 1 + 15);
      check("to_meas_count", q4.size(), 1);
      check("to_hold_period", int'(per4), 6);
      check("to_hold_high",   int'(hi4), 3 * DUTY);
      check("to_hold_duty",   int'(dok4), DUTY);
      q4.delete();
      rises.delete();
      sig4 = 1'b1;
      tick(); tick(); tick();
      check("to_clear", int'(to4), 0);
      check("to_first_rise_no_meas", q4.size(), 0);
      sig4 = 1'b0;
      repeat (4) tick();
      wave(7, 3, 1);
      idle(5);
      check("fresh_count", q4.size(), 1);
      if (q4.size() > 0) begin
         check("fresh_period", q4[0].per, 7);
         check("fresh_high",   q4[0].hi, 3 * DUTY);
         check("fresh_duty",   q4[0].dok, DUTY);
      end
      check("fresh_to", int'(to4), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
